cordic_ctrl: RTL and testbench

Sequencer for the 12-bit CORDIC rotation datapath in the scan-conversion pipeline. Accepts one polar-derived sample (X, Y, target angle) over a valid/ready handshake, applies quadrant pre-rotation, and drives the datapath's Start/Enable/Count/Theta_i/Delta_B through one load cycle and 12 micro-rotations. It then presents the rotated X/Y downstream over a second valid/ready handshake. It sits directly upstream of the iteration datapath and owns the residual-angle bookkeeping.

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_if.sv | 22 ++
 rtl/atan_rom.sv | 14 +
 rtl/cordic_ctrl.sv | 145 ++++++++++++++
 tb/tb_cordic_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, payload types and helpers for the CORDIC rotation sequencer.
package cordic_pkg;

  localparam int unsigned W     = 12;
  localparam int unsigned ITERS = 12;
  localparam int unsigned CW    = 4;

  // Micro-rotation angles, 2048 = pi; element [0] is the first iteration.
  localparam logic [ITERS-1:0][W-1:0] ATAN_TABLE = {
    12'd0, 12'd1, 12'd1, 12'd3, 12'd5, 12'd10,
    12'd20, 12'd41, 12'd81, 12'd160, 12'd302, 12'd512
  };

  localparam logic [W-1:0]  HALF_TURN = 12'h800;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] the;
  } sample_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } result_t;

  // Fold |theta| > pi/2 into the convergence range by rotating the vector by pi.
  function automatic sample_t pre_rotate(input sample_t s);
    sample_t r;
    r = s;
    if (s.the[W-1] != s.the[W-2]) begin
      r.x   = -s.x;
      r.y   = -s.y;
      r.the = s.the ^ HALF_TURN;
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_if.sv
// Sample-in / result-out valid-ready channels of the CORDIC sequencer.
interface cordic_if;
  import cordic_pkg::*;

  logic    in_valid;
  logic    in_ready;
  sample_t in_data;
  logic    out_valid;
  logic    out_ready;
  result_t out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/atan_rom.sv
// Arctangent lookup for the micro-rotation index; zero beyond the last iteration.
module atan_rom
  import cordic_pkg::*;
(
  input  logic [CW-1:0] idx,
  output logic [W-1:0]  atan_c
);

  always_comb begin
    atan_c = '0;
    if (idx < CW'(ITERS)) atan_c = ATAN_TABLE[idx];
  end

endmodule

// File: rtl/cordic_ctrl.sv
// Sequencer for the 12-bit CORDIC rotation datapath: accept, pre-rotate, load,
// 12 micro-rotations, then hold the rotated vector until downstream takes it.
module cordic_ctrl
  import cordic_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  cordic_if.slave       bus,
  output logic [W-1:0]  input_x,
  output logic [W-1:0]  input_y,
  output logic [W-1:0]  input_the,
  output logic [W-1:0]  theta_i,
  output logic          delta_b,
  output logic          start,
  output logic          enable,
  output logic [CW-1:0] count,
  input  logic [W-1:0]  x_out,
  input  logic [W-1:0]  y_out,
  input  logic [W-1:0]  theta_pre
);

  state_t        state_q, state_d;
  sample_t       op_q, op_d;
  result_t       res_q, res_d;
  logic [W-1:0]  z_q, z_d;
  logic [CW-1:0] count_d;
  logic [W-1:0]  theta_d;
  logic          delta_d, start_d, enable_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] rom_idx_c;
  logic [W-1:0]  rom_atan_c;
  logic          unused_theta_pre;

  // The residual angle is tracked locally, so the datapath angle is not needed.
  assign unused_theta_pre = ^theta_pre;

  // Table entry for the step that follows the current one.
  assign rom_idx_c = (state_q == ST_ITER) ? count + CW'(1) : '0;

  atan_rom u_atan_rom (
    .idx    (rom_idx_c),
    .atan_c (rom_atan_c)
  );

  assign input_x       = op_q.x;
  assign input_y       = op_q.y;
  assign input_the     = op_q.the;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      res_q       <= '0;
      z_q         <= '0;
      count       <= '0;
      theta_i     <= '0;
      delta_b     <= 1'b0;
      start       <= 1'b0;
      enable      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      res_q       <= res_d;
      z_q         <= z_d;
      count       <= count_d;
      theta_i     <= theta_d;
      delta_b     <= delta_d;
      start       <= start_d;
      enable      <= enable_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    res_d       = res_q;
    z_d         = z_q;
    count_d     = count;
    theta_d     = '0;
    delta_d     = 1'b0;
    start_d     = 1'b0;
    enable_d    = 1'b0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          state_d    = ST_LOAD;
          op_d       = pre_rotate(bus.in_data);
          z_d        = op_d.the;
          start_d    = 1'b1;
          enable_d   = 1'b1;
          count_d    = '0;
          in_ready_d = 1'b0;
        end
      end

      ST_LOAD: begin
        state_d  = ST_ITER;
        enable_d = 1'b1;
        count_d  = '0;
        theta_d  = rom_atan_c;
        delta_d  = z_q[W-1];
      end

      ST_ITER: begin
        z_d = delta_b ? z_q + theta_i : z_q - theta_i;
        if (count == LAST_ITER) begin
          state_d     = ST_DONE;
          count_d     = '0;
          out_valid_d = 1'b1;
          res_d       = '{x: x_out, y: y_out};
        end else begin
          enable_d = 1'b1;
          count_d  = count + CW'(1);
          theta_d  = rom_atan_c;
          delta_d  = z_d[W-1];
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_ctrl.sv
// Bench for cordic_ctrl: behavioural datapath, spec-level residual/rotation model.
module tb_cordic_ctrl;
  import cordic_pkg::*;

  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cordic_if bus ();

  logic [W-1:0]  input_x, input_y, input_the, theta_i;
  logic          delta_b, start, enable;
  logic [CW-1:0] count;
  logic signed [W-1:0] dp_x, dp_y, dp_t;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  atan_ref [ITERS];
  real k_gain;

  cordic_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .input_x   (input_x),
    .input_y   (input_y),
    .input_the (input_the),
    .theta_i   (theta_i),
    .delta_b   (delta_b),
    .start     (start),
    .enable    (enable),
    .count     (count),
    .x_out     (dp_x),
    .y_out     (dp_y),
    .theta_pre (dp_t)
  );

  // Iteration datapath: load on Start, otherwise one shift-add micro-rotation.
  always @(posedge clk) begin
    if (enable) begin
      if (start) begin
        dp_x <= input_x;
        dp_y <= input_y;
        dp_t <= input_the;
      end else if (delta_b) begin
        dp_x <= dp_x + (dp_y >>> count);
        dp_y <= dp_y - (dp_x >>> count);
        dp_t <= dp_t + theta_i;
      end else begin
        dp_x <= dp_x - (dp_y >>> count);
        dp_y <= dp_y + (dp_x >>> count);
        dp_t <= dp_t - theta_i;
      end
    end
  end

  function automatic int s12(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int wrap12(input int v);
    int r;
    r = v % 4096;
    if (r < 0) r += 4096;
    if (r >= 2048) r -= 4096;
    return r;
  endfunction

  // Exact rotation by the requested angle, scaled by the CORDIC gain.
  function automatic void ideal_rot(input int x, input int y, input int the,
                                    output real ex, output real ey);
    real th;
    th = real'(wrap12(the)) * PI / 2048.0;
    ex = k_gain * (real'(x) * $cos(th) - real'(y) * $sin(th));
    ey = k_gain * (real'(x) * $sin(th) + real'(y) * $cos(th));
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive one sample and follow it from accept to DONE entry.
  task automatic run_sample(input int x, input int y, input int the,
                            output int ld_x, output int ld_the,
                            output int rx, output int ry);
    int sth, px, py, pth, z, waited;
    ld_x = 0; ld_the = 0; rx = 0; ry = 0;
    sth = wrap12(the);
    if (sth >= 1024 || sth < -1024) begin
      px = wrap12(-x); py = wrap12(-y); pth = wrap12(sth + 2048);
    end else begin
      px = x; py = y; pth = sth;
    end
    bus.in_data.x   = W'(x);
    bus.in_data.y   = W'(y);
    bus.in_data.the = W'(the);
    bus.in_valid    = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 40) begin
      step;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    step;
    bus.in_valid = 1'b0;

    n_checks++;
    if ({start, enable, count, bus.in_ready, bus.out_valid} !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0})
      $display("FAIL load_strobe: st/en/cnt/ir/ov=%b required 11000000",
               {start, enable, count, bus.in_ready, bus.out_valid});
    else n_pass++;

    n_checks++;
    if (s12(input_x) !== px || s12(input_y) !== py || s12(input_the) !== pth)
      $display("FAIL load_operands: x=%0d y=%0d the=%0d required x=%0d y=%0d the=%0d",
               s12(input_x), s12(input_y), s12(input_the), px, py, pth);
    else n_pass++;
    ld_x   = s12(input_x);
    ld_the = s12(input_the);

    z = pth;
    for (int i = 0; i < ITERS; i++) begin
      step;
      n_checks++;
      if (int'(count) !== i || int'(theta_i) !== atan_ref[i] || enable !== 1'b1 ||
          start !== 1'b0 || bus.out_valid !== 1'b0)
        $display("FAIL iter_seq[%0d]: count=%0d theta_i=%0d en=%b st=%b ov=%b required count=%0d theta_i=%0d en=1 st=0 ov=0",
                 i, count, theta_i, enable, start, bus.out_valid, i, atan_ref[i]);
      else n_pass++;
      n_checks++;
      if (delta_b !== (z < 0))
        $display("FAIL delta_b[%0d]: delta_b=%b required %b (residual %0d)", i, delta_b, (z < 0), z);
      else n_pass++;
      z = wrap12((z < 0) ? z + atan_ref[i] : z - atan_ref[i]);
    end

    step;
    n_checks++;
    if (bus.out_valid !== 1'b1 || enable !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL done_entry: ov=%b en=%b ir=%b required ov=1 en=0 ir=0",
               bus.out_valid, enable, bus.in_ready);
    else n_pass++;
    rx = s12(bus.out_data.x);
    ry = s12(bus.out_data.y);
  endtask

  // With out_ready high, one more edge must return to IDLE.
  task automatic finish_sample;
    bus.out_ready = 1'b1;
    step;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL done_to_idle: ov=%b ir=%b required ov=0 ir=1", bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_reset;
    bit bad;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    step;
    step;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, start, enable, delta_b, count, theta_i,
         input_x, input_y, input_the, bus.out_data} !== {1'b1, 80'd0})
      $display("FAIL reset_values: ir=%b ov=%b st=%b en=%b db=%b cnt=%0d th=%0d in=%h/%h/%h out=%h required ir=1, rest 0",
               bus.in_ready, bus.out_valid, start, enable, delta_b, count, theta_i,
               input_x, input_y, input_the, bus.out_data);
    else n_pass++;
    #3 rst_n = 1'b1;
    step;

    // Abort a sample in the middle of its micro-rotations.
    bus.in_data.x = W'(500);
    bus.in_data.y = W'(300);
    bus.in_data.the = W'(700);
    bus.in_valid = 1'b1;
    step;
    bus.in_valid = 1'b0;
    repeat (7) step;
    n_checks++;
    if (count !== 4'd6 || enable !== 1'b1)
      $display("FAIL pre_reset_count: count=%0d en=%b required count=6 en=1", count, enable);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({start, enable, bus.out_valid, bus.in_ready, count} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd0})
      $display("FAIL async_abort: st=%b en=%b ov=%b ir=%b cnt=%0d required 0 0 0 1 0",
               start, enable, bus.out_valid, bus.in_ready, count);
    else n_pass++;
    #2 rst_n = 1'b1;
    step;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || enable !== 1'b0) bad = 1'b1;
      step;
    end
    n_checks++;
    if (bad) $display("FAIL no_spurious_result: ov/ir/en deviated from 0/1/0 after abort");
    else n_pass++;
  endtask

  task automatic test_directed;
    int ld_x, ld_the, rx, ry;
    int angles [4] = '{1024, -1024, -2048, 2047};
    real ex, ey;
    bus.out_ready = 1'b1;

    run_sample(1000, 0, 0, ld_x, ld_the, rx, ry);
    n_checks++;
    if (rx < 1643 || rx > 1651 || ry < -4 || ry > 4)
      $display("FAIL rot_0: out=(%0d,%0d) required (1647+-4, 0+-4)", rx, ry);
    else n_pass++;
    finish_sample;

    run_sample(1000, 0, 512, ld_x, ld_the, rx, ry);
    n_checks++;
    if (rx < 1159 || rx > 1171 || ry < 1159 || ry > 1171)
      $display("FAIL rot_pi4: out=(%0d,%0d) required (1165+-6, 1165+-6)", rx, ry);
    else n_pass++;
    finish_sample;

    run_sample(1000, 0, 1536, ld_x, ld_the, rx, ry);
    n_checks++;
    if (ld_x !== -1000 || ld_the !== -512)
      $display("FAIL prerot_3pi4: input_x=%0d input_the=%0d required -1000 -512", ld_x, ld_the);
    else n_pass++;
    n_checks++;
    if (rx < -1171 || rx > -1159 || ry < 1159 || ry > 1171)
      $display("FAIL rot_3pi4: out=(%0d,%0d) required (-1165+-6, 1165+-6)", rx, ry);
    else n_pass++;
    finish_sample;

    foreach (angles[k]) begin
      run_sample(1000, 0, angles[k], ld_x, ld_the, rx, ry);
      ideal_rot(1000, 0, angles[k], ex, ey);
      n_checks++;
      if (rabs(real'(rx) - ex) > 8.0 || rabs(real'(ry) - ey) > 8.0)
        $display("FAIL rot_boundary[%0d]: out=(%0d,%0d) required (%0.1f,%0.1f)+-8", angles[k], rx, ry, ex, ey);
      else n_pass++;
      finish_sample;
    end
  endtask

  task automatic test_random;
    int x, y, the, ld_x, ld_the, rx, ry;
    real ex, ey;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      x   = int'($urandom_range(1680)) - 840;
      y   = int'($urandom_range(1680)) - 840;
      the = int'($urandom_range(4095));
      run_sample(x, y, the, ld_x, ld_the, rx, ry);
      ideal_rot(x, y, the, ex, ey);
      n_checks++;
      if (rabs(real'(rx) - ex) > 24.0 || rabs(real'(ry) - ey) > 24.0)
        $display("FAIL rot_random[%0d]: in=(%0d,%0d,%0d) out=(%0d,%0d) required (%0.1f,%0.1f)+-24",
                 n, x, y, the, rx, ry, ex, ey);
      else n_pass++;
      finish_sample;
    end
  endtask

  task automatic test_backpressure;
    int ld_x, ld_the, rx, ry, waited;
    real ex, ey;
    result_t held;
    bus.out_ready = 1'b0;
    run_sample(700, -200, 300, ld_x, ld_the, rx, ry);
    ideal_rot(700, -200, 300, ex, ey);
    n_checks++;
    if (rabs(real'(rx) - ex) > 24.0 || rabs(real'(ry) - ey) > 24.0)
      $display("FAIL rot_backpressure: out=(%0d,%0d) required (%0.1f,%0.1f)+-24", rx, ry, ex, ey);
    else n_pass++;
    held = bus.out_data;
    bus.in_data.x = W'(-300);
    bus.in_data.y = W'(400);
    bus.in_data.the = W'(-900);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0 || start !== 1'b0)
        $display("FAIL hold[%0d]: ov=%b out=%h ir=%b st=%b required ov=1 out=%h ir=0 st=0",
                 i, bus.out_valid, bus.out_data, bus.in_ready, start, held);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    step;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || start !== 1'b0)
      $display("FAIL release_only: ov=%b ir=%b st=%b required 0 1 0", bus.out_valid, bus.in_ready, start);
    else n_pass++;
    step;
    n_checks++;
    if (start !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL accept_after_idle: st=%b ir=%b required 1 0", start, bus.in_ready);
    else n_pass++;
    bus.in_valid = 1'b0;
    waited = 0;
    while (!(bus.in_ready === 1'b1 && bus.out_valid === 1'b0) && waited < 40) begin
      step;
      waited++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL drain_backpressure: ir=%b required 1 within 40 cycles", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int waited, cyc, en_cnt;
    bit found;
    bus.out_ready = 1'b1;
    bus.in_data.x = W'(-640);
    bus.in_data.y = W'(512);
    bus.in_data.the = W'(-333);
    bus.in_valid = 1'b1;
    waited = 0;
    while (start !== 1'b1 && waited < 40) begin
      step;
      waited++;
    end
    n_checks++;
    if (start !== 1'b1) begin
      $display("FAIL b2b_first_start: start=%b required 1 within 40 cycles", start);
    end else begin
      n_pass++;
      cyc = 0;
      en_cnt = 1;
      found = 1'b0;
      while (cyc < 40) begin
        step;
        cyc++;
        if (start === 1'b1) begin
          found = 1'b1;
          break;
        end
        en_cnt += int'(enable);
      end
      n_checks++;
      if (!found || cyc !== 15)
        $display("FAIL b2b_period: period=%0d found=%b required 15", cyc, found);
      else n_pass++;
      n_checks++;
      if (en_cnt !== 13)
        $display("FAIL b2b_enable_cycles: enable cycles=%0d required 13", en_cnt);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    waited = 0;
    while (!(bus.in_ready === 1'b1 && bus.out_valid === 1'b0) && waited < 40) begin
      step;
      waited++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL b2b_drain: ir=%b required 1 within 40 cycles", bus.in_ready);
    else n_pass++;
  endtask

  initial begin
    k_gain = 1.0;
    for (int i = 0; i < ITERS; i++) begin
      atan_ref[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 2048.0 / PI + 0.5);
      k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
